// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencer: operand and accumulator widths
// and the sequencer state encoding.
package mac_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ACC_W  = 39;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACCUM = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } mac_state_t;

endpackage : mac_pkg

// File: rtl/mac_sequencer.sv
// Dot-product sequencer. It feeds operand pairs into an external accumulating
// ALU and presents the final accumulator value through a valid/ready result
// handshake. The ALU itself lives at the integration level.
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int unsigned LEN_W = 8
) (
    input  logic              clk,
    input  logic              R_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] alu_X,
    output logic [DATA_W-1:0] alu_B,
    output logic              alu_valid_in,
    output logic              alu_R,
    input  logic [ACC_W-1:0]  alu_y,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [ACC_W-1:0]  result_data
);

    mac_state_t       state;
    logic [LEN_W-1:0] remaining;
    logic             xfer;

    assign xfer = in_valid && in_ready;

    // Control FSM with registered handshake and ALU-drive outputs.
    // alu_R and alu_valid_in default low each cycle so they act as single-cycle pulses.
    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            state        <= IDLE;
            remaining    <= '0;
            alu_X        <= '0;
            alu_B        <= '0;
            alu_valid_in <= 1'b0;
            alu_R        <= 1'b1;
            in_ready     <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            alu_valid_in <= 1'b0;
            alu_R        <= 1'b0;
            if (abort && (state != IDLE)) begin
                state        <= IDLE;
                remaining    <= '0;
                alu_R        <= 1'b1;
                in_ready     <= 1'b0;
                result_valid <= 1'b0;
                busy         <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            remaining <= len;
                            alu_R     <= 1'b1;
                            busy      <= 1'b1;
                            state     <= CLEAR;
                        end
                    end
                    CLEAR: begin
                        if (remaining != '0) begin
                            in_ready <= 1'b1;
                            state    <= ACCUM;
                        end else begin
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end
                    end
                    ACCUM: begin
                        if (xfer) begin
                            alu_X        <= in_x;
                            alu_B        <= in_b;
                            alu_valid_in <= 1'b1;
                            remaining    <= remaining - 1'b1;
                            if (remaining == LEN_W'(1)) begin
                                in_ready <= 1'b0;
                                state    <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end
                    DONE: begin
                        if (result_ready) begin
                            result_valid <= 1'b0;
                            busy         <= 1'b0;
                            state        <= IDLE;
                        end
                    end
                    default: begin
                        in_ready     <= 1'b0;
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                endcase
            end
        end
    end

    // The ALU has already absorbed the last pair when DONE is entered, so the
    // accumulator is passed straight through rather than re-registered.
    always_comb begin
        result_data = '0;
        if (state == DONE) begin
            result_data = alu_y;
        end
    end

endmodule : mac_sequencer

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer with a behavioural accumulating ALU.
module tb_mac_sequencer;
    import mac_pkg::*;

    logic              clk;
    logic              R_n;
    logic              start;
    logic [7:0]        len;
    logic              abort;
    logic              busy;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_x;
    logic [15:0]       in_b;
    logic [15:0]       alu_X;
    logic [15:0]       alu_B;
    logic              alu_valid_in;
    logic              alu_R;
    logic [38:0]       alu_y;
    logic              result_valid;
    logic              result_ready;
    logic [38:0]       result_data;

    int checks;
    int errors;

    mac_sequencer #(.LEN_W(8)) dut (
        .clk          (clk),
        .R_n          (R_n),
        .start        (start),
        .len          (len),
        .abort        (abort),
        .busy         (busy),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_b         (in_b),
        .alu_X        (alu_X),
        .alu_B        (alu_B),
        .alu_valid_in (alu_valid_in),
        .alu_R        (alu_R),
        .alu_y        (alu_y),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_data  (result_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accumulating ALU model: clear on alu_R, add signed product on alu_valid_in.
    logic signed [31:0] prod;
    assign prod = $signed(alu_X) * $signed(alu_B);
    always @(posedge clk) begin
        if (alu_R) alu_y <= '0;
        else if (alu_valid_in) alu_y <= alu_y + {{7{prod[31]}}, prod};
    end

    typedef struct {
        logic        start;
        logic [7:0]  len;
        logic        abort;
        logic        iv;
        logic [15:0] x;
        logic [15:0] b;
        logic        rr;
        logic        e_busy;
        logic        e_rdy;
        logic        e_av;
        logic        e_r;
        logic        e_rv;
        logic [38:0] e_rd;
        logic [15:0] e_x;
        logic [15:0] e_b;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic s, input logic [7:0] l, input logic ab, input logic iv,
                                input logic [15:0] x, input logic [15:0] b, input logic rr,
                                input logic eb, input logic erdy, input logic eav, input logic er,
                                input logic erv, input logic [38:0] erd, input logic [15:0] ex,
                                input logic [15:0] ebb);
        vec_t v;
        v.start = s; v.len = l; v.abort = ab; v.iv = iv; v.x = x; v.b = b; v.rr = rr;
        v.e_busy = eb; v.e_rdy = erdy; v.e_av = eav; v.e_r = er; v.e_rv = erv;
        v.e_rd = erd; v.e_x = ex; v.e_b = ebb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, " alu_valid_in"}, 64'(alu_valid_in), 64'd0);
        chk({tag, " alu_R"}, 64'(alu_R), 64'd1);
        chk({tag, " result_valid"}, 64'(result_valid), 64'd0);
        chk({tag, " result_data"}, 64'(result_data), 64'd0);
        chk({tag, " alu_X"}, 64'(alu_X), 64'd0);
        chk({tag, " alu_B"}, 64'(alu_B), 64'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        R_n = 1'b0; start = 1'b0; len = '0; abort = 1'b0;
        in_valid = 1'b0; in_x = '0; in_b = '0; result_ready = 1'b0;

        //        st len ab iv  x  b rr | busy rdy av R rv  rd  X  B
        // len=3, pairs (1,2),(3,4),(5,6) -> 44
        vq.push_back(mk(1, 3, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0,  0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0,  0, 0, 0));
        vq.push_back(mk(0, 0, 0, 1, 1, 2, 0,  1, 1, 1, 0, 0,  0, 1, 2));
        vq.push_back(mk(0, 0, 0, 1, 3, 4, 0,  1, 1, 1, 0, 0,  0, 3, 4));
        vq.push_back(mk(0, 0, 0, 1, 5, 6, 0,  1, 0, 1, 0, 0,  0, 5, 6));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 44, 5, 6));
        vq.push_back(mk(1, 7, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 44, 5, 6));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0,  0, 5, 6));
        // len=0 -> CLEAR then DONE with 0
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0,  0, 5, 6));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1,  0, 5, 6));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0,  0, 5, 6));
        // len=4, abort after one transfer; abort beats start and transfer
        vq.push_back(mk(1, 4, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0,  0, 5, 6));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0,  0, 5, 6));
        vq.push_back(mk(0, 0, 0, 1, 9, 9, 0,  1, 1, 1, 0, 0,  0, 9, 9));
        vq.push_back(mk(1, 2, 1, 1, 7, 7, 0,  0, 0, 0, 1, 0,  0, 9, 9));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 9, 9));
        // abort in IDLE is ignored
        vq.push_back(mk(0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 9, 9));
        // len=1, pair (2,2) -> 4
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0,  0, 9, 9));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0,  0, 9, 9));
        vq.push_back(mk(0, 0, 0, 1, 2, 2, 0,  1, 0, 1, 0, 0,  0, 2, 2));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1,  4, 2, 2));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0,  0, 2, 2));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        R_n = 1'b1;
        step();
        chk("post-reset alu_R", 64'(alu_R), 64'd0);
        chk("post-reset busy", 64'(busy), 64'd0);

        // Table-driven vectors
        for (int i = 0; i < vq.size(); i++) begin
            start = vq[i].start; len = vq[i].len; abort = vq[i].abort;
            in_valid = vq[i].iv; in_x = vq[i].x; in_b = vq[i].b; result_ready = vq[i].rr;
            step();
            chk($sformatf("v%0d busy", i), 64'(busy), 64'(vq[i].e_busy));
            chk($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(vq[i].e_rdy));
            chk($sformatf("v%0d alu_valid_in", i), 64'(alu_valid_in), 64'(vq[i].e_av));
            chk($sformatf("v%0d alu_R", i), 64'(alu_R), 64'(vq[i].e_r));
            chk($sformatf("v%0d result_valid", i), 64'(result_valid), 64'(vq[i].e_rv));
            chk($sformatf("v%0d result_data", i), 64'(result_data), 64'(vq[i].e_rd));
            chk($sformatf("v%0d alu_X", i), 64'(alu_X), 64'(vq[i].e_x));
            chk($sformatf("v%0d alu_B", i), 64'(alu_B), 64'(vq[i].e_b));
        end
        start = 1'b0; abort = 1'b0; in_valid = 1'b0; result_ready = 1'b0;

        // Stalled input and stalled result: len=2, (7,8) gap (2,3) -> 62
        start = 1'b1; len = 8'd2;
        step();
        start = 1'b0;
        step();
        chk("stall in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_x = 16'd7; in_b = 16'd8;
        step();
        chk("stall first alu_valid_in", 64'(alu_valid_in), 64'd1);
        in_valid = 1'b0; start = 1'b1; len = 8'd9;
        for (int g = 0; g < 4; g++) begin
            step();
            chk($sformatf("gap%0d in_ready", g), 64'(in_ready), 64'd1);
            chk($sformatf("gap%0d alu_valid_in", g), 64'(alu_valid_in), 64'd0);
            chk($sformatf("gap%0d alu_X", g), 64'(alu_X), 64'd7);
            chk($sformatf("gap%0d alu_B", g), 64'(alu_B), 64'd8);
        end
        start = 1'b0;
        in_valid = 1'b1; in_x = 16'd2; in_b = 16'd3;
        step();
        chk("stall drain in_ready", 64'(in_ready), 64'd0);
        chk("stall drain result_valid", 64'(result_valid), 64'd0);
        in_valid = 1'b0;
        step();
        for (int h = 0; h < 5; h++) begin
            chk($sformatf("hold%0d result_valid", h), 64'(result_valid), 64'd1);
            chk($sformatf("hold%0d result_data", h), 64'(result_data), 64'd62);
            if (h < 4) step();
        end
        result_ready = 1'b1;
        step();
        chk("stall done busy", 64'(busy), 64'd0);
        chk("stall done result_valid", 64'(result_valid), 64'd0);
        result_ready = 1'b0;

        // Asynchronous reset in the middle of ACCUM discards the job
        start = 1'b1; len = 8'd3;
        step();
        start = 1'b0;
        step();
        in_valid = 1'b1; in_x = 16'd4; in_b = 16'd4;
        step();
        in_valid = 1'b0;
        chk("pre-reset alu_X", 64'(alu_X), 64'd4);
        #2;
        R_n = 1'b0;
        #1;
        chk_reset_outputs("async reset");
        step();
        step();
        R_n = 1'b1;
        step();
        chk("re-reset alu_R", 64'(alu_R), 64'd0);
        chk("re-reset result_valid", 64'(result_valid), 64'd0);
        chk("re-reset busy", 64'(busy), 64'd0);

        // Fresh job after reset: len=1, (3,3) -> 9
        start = 1'b1; len = 8'd1;
        step();
        start = 1'b0;
        step();
        in_valid = 1'b1; in_x = 16'd3; in_b = 16'd3;
        step();
        in_valid = 1'b0;
        step();
        chk("after reset result_valid", 64'(result_valid), 64'd1);
        chk("after reset result_data", 64'(result_data), 64'd9);
        result_ready = 1'b1;
        step();
        chk("after reset idle", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mac_sequencer
